// File: rtl/nlc_frame_serializer_if.sv
// +------------------------------------------------------------------+
// | nlc_frame_serializer_if: NLC frame input / sample stream bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface nlc_frame_serializer_if #(
  parameter int NUM_CH = 16,
  parameter int DW     = 21
);
  localparam int CW = $clog2(NUM_CH);

  logic          srdyo;
  logic [DW-1:0] ch0_x_lin;
  logic [DW-1:0] ch1_x_lin;
  logic [DW-1:0] ch2_x_lin;
  logic [DW-1:0] ch3_x_lin;
  logic [DW-1:0] ch4_x_lin;
  logic [DW-1:0] ch5_x_lin;
  logic [DW-1:0] ch6_x_lin;
  logic [DW-1:0] ch7_x_lin;
  logic [DW-1:0] ch8_x_lin;
  logic [DW-1:0] ch9_x_lin;
  logic [DW-1:0] ch10_x_lin;
  logic [DW-1:0] ch11_x_lin;
  logic [DW-1:0] ch12_x_lin;
  logic [DW-1:0] ch13_x_lin;
  logic [DW-1:0] ch14_x_lin;
  logic [DW-1:0] ch15_x_lin;
  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic [CW-1:0] dout_ch;
  logic          dout_last;
  logic          clr_ovf;
  logic          overflow;
  logic [7:0]    drop_cnt;

  modport master (
    output srdyo, ch0_x_lin, ch1_x_lin, ch2_x_lin, ch3_x_lin, ch4_x_lin,
           ch5_x_lin, ch6_x_lin, ch7_x_lin, ch8_x_lin, ch9_x_lin, ch10_x_lin,
           ch11_x_lin, ch12_x_lin, ch13_x_lin, ch14_x_lin, ch15_x_lin,
           dout_ready, clr_ovf,
    input  dout_valid, dout_data, dout_ch, dout_last, overflow, drop_cnt
  );

  modport slave (
    input  srdyo, ch0_x_lin, ch1_x_lin, ch2_x_lin, ch3_x_lin, ch4_x_lin,
           ch5_x_lin, ch6_x_lin, ch7_x_lin, ch8_x_lin, ch9_x_lin, ch10_x_lin,
           ch11_x_lin, ch12_x_lin, ch13_x_lin, ch14_x_lin, ch15_x_lin,
           dout_ready, clr_ovf,
    output dout_valid, dout_data, dout_ch, dout_last, overflow, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/nlc_frame_serializer.sv
// +------------------------------------------------------------------+
// | nlc_frame_serializer: two-slot frame buffer, one channel/cycle   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module nlc_frame_serializer #(
  parameter int NUM_CH = 16,
  parameter int DW     = 21
) (
  input  wire                   clk,
  input  wire                   reset,
  nlc_frame_serializer_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CH - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    occ_q, occ_d;
  logic          wp_q, rp_q;
  logic [CW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [DW-1:0] slot_q [2][NUM_CH];
  logic [DW-1:0] frame [NUM_CH];

  logic sending, hs, rel, accept, drop;

  always_comb begin
    frame[0]  = bus.ch0_x_lin;
    frame[1]  = bus.ch1_x_lin;
    frame[2]  = bus.ch2_x_lin;
    frame[3]  = bus.ch3_x_lin;
    frame[4]  = bus.ch4_x_lin;
    frame[5]  = bus.ch5_x_lin;
    frame[6]  = bus.ch6_x_lin;
    frame[7]  = bus.ch7_x_lin;
    frame[8]  = bus.ch8_x_lin;
    frame[9]  = bus.ch9_x_lin;
    frame[10] = bus.ch10_x_lin;
    frame[11] = bus.ch11_x_lin;
    frame[12] = bus.ch12_x_lin;
    frame[13] = bus.ch13_x_lin;
    frame[14] = bus.ch14_x_lin;
    frame[15] = bus.ch15_x_lin;
  end

  // A full buffer still accepts when the slot being read is freed this cycle.
  assign sending = (state_q == S_SEND);
  assign hs      = sending & bus.dout_ready;
  assign rel     = hs & (idx_q == LAST_IDX);
  assign accept  = bus.srdyo & ((occ_q != 2'd2) | rel);
  assign drop    = bus.srdyo & ~accept;
  assign occ_d   = occ_q + {1'b0, accept} - {1'b0, rel};
  assign idx_d   = hs ? (rel ? '0 : idx_q + CW'(1)) : idx_q;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clr_ovf)
        drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      occ_q      <= 2'd0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      wp_q       <= wp_q ^ accept;
      rp_q       <= rp_q ^ rel;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Frame storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int n = 0; n < NUM_CH; n++)
        slot_q[wp_q][n] <= frame[n];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (occ_d != 2'd0) state_d = S_SEND;
      S_SEND:  if (rel && (occ_d == 2'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dout_valid = 1'b0;
    bus.dout_data  = '0;
    bus.dout_ch    = '0;
    bus.dout_last  = 1'b0;
    if (sending) begin
      bus.dout_valid = 1'b1;
      bus.dout_data  = slot_q[rp_q][idx_q];
      bus.dout_ch    = idx_q;
      bus.dout_last  = (idx_q == LAST_IDX);
    end
  end

  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nlc_frame_serializer.sv
// +------------------------------------------------------------------+
// | tb_nlc_frame_serializer: directed self-checking bench            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_nlc_frame_serializer;
  logic clk;
  logic reset;
  logic [20:0] chv [16];
  int n_checks;
  int n_errors;

  nlc_frame_serializer_if #(.NUM_CH(16), .DW(21)) bif ();

  nlc_frame_serializer #(.NUM_CH(16), .DW(21)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  assign bif.ch0_x_lin  = chv[0];
  assign bif.ch1_x_lin  = chv[1];
  assign bif.ch2_x_lin  = chv[2];
  assign bif.ch3_x_lin  = chv[3];
  assign bif.ch4_x_lin  = chv[4];
  assign bif.ch5_x_lin  = chv[5];
  assign bif.ch6_x_lin  = chv[6];
  assign bif.ch7_x_lin  = chv[7];
  assign bif.ch8_x_lin  = chv[8];
  assign bif.ch9_x_lin  = chv[9];
  assign bif.ch10_x_lin = chv[10];
  assign bif.ch11_x_lin = chv[11];
  assign bif.ch12_x_lin = chv[12];
  assign bif.ch13_x_lin = chv[13];
  assign bif.ch14_x_lin = chv[14];
  assign bif.ch15_x_lin = chv[15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame f, channel n carries f<<16 | n<<12 | n; frame 0 is N*0x1000+N.
  function automatic logic [20:0] sval(input int f, input int n);
    sval = 21'((f << 16) | (n << 12) | n);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int f);
    for (int n = 0; n < 16; n++) chv[n] = sval(f, n);
  endtask

  task automatic strobe(input int f);
    set_frame(f);
    bif.srdyo = 1'b1;
    tick();
    bif.srdyo = 1'b0;
  endtask

  // Expects channel 0 of frame f on the outputs; accepts cnt samples.
  task automatic drain(input int f, input int cnt);
    bif.dout_ready = 1'b1;
    for (int n = 0; n < cnt; n++) begin
      check("drain_valid", bif.dout_valid, 1);
      check("drain_ch", bif.dout_ch, n);
      check("drain_data", bif.dout_data, sval(f, n));
      check("drain_last", bif.dout_last, (n == 15) ? 1 : 0);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, bif.dout_valid, 0);
  endtask

  initial begin
    int exp_n;
    int cyc;
    logic [4:0] pat;
    n_checks = 0;
    n_errors = 0;
    pat = 5'b01101;
    reset = 1'b1;
    bif.srdyo = 1'b0;
    bif.dout_ready = 1'b0;
    bif.clr_ovf = 1'b0;
    set_frame(0);
    tick();
    tick();
    check("rst_valid", bif.dout_valid, 0);
    check("rst_data", bif.dout_data, 0);
    check("rst_ch", bif.dout_ch, 0);
    check("rst_last", bif.dout_last, 0);
    check("rst_ovf", bif.overflow, 0);
    check("rst_cnt", bif.drop_cnt, 0);
    reset = 1'b0;
    tick();

    // Basic capture and drain: ch 0 visible one cycle after the strobe.
    bif.dout_ready = 1'b1;
    strobe(0);
    drain(0, 16);
    check_idle("basic_idle");

    // Backpressure with ready pattern 1,0,1,1,0 (pat bit 0 first).
    bif.dout_ready = 1'b0;
    strobe(1);
    exp_n = 0;
    cyc = 0;
    while (exp_n < 16 && cyc < 100) begin
      bif.dout_ready = pat[cyc % 5];
      check("bp_valid", bif.dout_valid, 1);
      check("bp_ch", bif.dout_ch, exp_n);
      check("bp_data", bif.dout_data, sval(1, exp_n));
      check("bp_last", bif.dout_last, (exp_n == 15) ? 1 : 0);
      if (bif.dout_ready) exp_n++;
      cyc++;
      tick();
    end
    check("bp_count", exp_n, 16);
    check_idle("bp_idle");

    // Overflow: third strobe against a full buffer is dropped.
    bif.dout_ready = 1'b0;
    strobe(2);
    strobe(3);
    strobe(4);
    check("ovf_flag", bif.overflow, 1);
    check("ovf_cnt", bif.drop_cnt, 1);
    drain(2, 16);
    drain(3, 16);
    check_idle("ovf_idle");

    // Coincident release: strobe on the ch-15 handshake with both slots full.
    bif.dout_ready = 1'b0;
    strobe(5);
    strobe(6);
    drain(5, 15);
    check("coin_ch15", bif.dout_ch, 15);
    check("coin_last", bif.dout_last, 1);
    bif.dout_ready = 1'b1;
    strobe(7);
    check("coin_nodrop", bif.drop_cnt, 1);
    bif.dout_ready = 1'b0;
    strobe(8);
    check("coin_full", bif.drop_cnt, 2);
    drain(6, 16);
    drain(7, 16);
    check_idle("coin_idle");

    // Clear vs drop, plus counter saturation.
    bif.clr_ovf = 1'b1;
    tick();
    bif.clr_ovf = 1'b0;
    check("clr_ovf0", bif.overflow, 0);
    check("clr_cnt0", bif.drop_cnt, 0);
    bif.dout_ready = 1'b0;
    strobe(9);
    strobe(10);
    set_frame(11);
    bif.srdyo = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("drop5_cnt", bif.drop_cnt, 5);
    bif.clr_ovf = 1'b1;
    tick();
    bif.clr_ovf = 1'b0;
    check("clrdrop_ovf", bif.overflow, 1);
    check("clrdrop_cnt", bif.drop_cnt, 1);
    for (int k = 0; k < 260; k++) tick();
    bif.srdyo = 1'b0;
    check("sat_cnt", bif.drop_cnt, 255);
    bif.clr_ovf = 1'b1;
    tick();
    bif.clr_ovf = 1'b0;
    check("clr_ovf1", bif.overflow, 0);
    check("clr_cnt1", bif.drop_cnt, 0);
    drain(9, 16);
    drain(10, 16);
    check_idle("clr_idle");

    // Asynchronous reset while channel 7 is on the outputs.
    strobe(12);
    drain(12, 7);
    check("pre_rst_ch", bif.dout_ch, 7);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", bif.dout_valid, 0);
    check("arst_data", bif.dout_data, 0);
    check("arst_ch", bif.dout_ch, 0);
    check("arst_last", bif.dout_last, 0);
    tick();
    reset = 1'b0;
    tick();
    check_idle("arst_idle");
    strobe(13);
    drain(13, 16);
    check_idle("arst_end_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nlc_frame_serializer.md
# nlc_frame_serializer

Receive side of the 16-channel nonlinearity-correction output interface. On each `srdyo` strobe from the NLC datapath, the block captures all sixteen 21-bit corrected samples `ch0_x_lin`..`ch15_x_lin` into a two-frame buffer. It then streams the samples out one channel per cycle over a valid/ready interface toward the downstream sample sink. It absorbs backpressure and flags frames it had to drop.

## Interface
- `NUM_CH`, 16: channels per frame; fixed to match the NLC output bus.
- `DW`, 21: sample width.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `srdyo`  input  1  frame strobe from the NLC; the `chN_x_lin` buses are valid in this cycle.
- `chN_x_lin` (N=0..15)  input  21 each  corrected samples, captured on `srdyo`.
- `dout_ready`  input  1  downstream can accept a sample this cycle.
- `dout_valid`  output  1  `dout_data` and `dout_ch` hold a sample.
- `dout_data`  output  21  sample value.
- `dout_ch`  output  4  channel index of `dout_data` (0..15).
- `dout_last`  output  1  high with channel 15 of each frame.
- `clr_ovf`  input  1  clears `overflow` and `drop_cnt`.
- `overflow`  output  1  sticky; set when a frame is dropped.
- `drop_cnt`  output  8  count of dropped frames; saturates at 255.

## Operation
- **Buffer.** Two frame slots of 16×21 bits, with write pointer `wp`, read pointer `rp` and occupancy `occ` (0..2).
- **Capture.**
  - `srdyo`=1 is accepted when `occ`<2, or when `occ`=2 and the final handshake of the current frame (ch 15, `dout_valid`&`dout_ready`) occurs in the same cycle.
  - On accept, all 16 buses are written to slot `wp` and `wp` toggles.
  - Otherwise the frame is dropped entirely (no partial writes), `overflow` is set to 1, and `drop_cnt` increments, saturating at 255.
- **Occupancy update per cycle.** `occ_next` = `occ` + accept − release, where release = a ch-15 handshake.
- **Read FSM.**
  - IDLE: `dout_valid`=0. Go to SEND when `occ`>0 at a clock edge.
  - SEND: `dout_valid`=1, `dout_data`=slot[`rp`][`idx`], `dout_ch`=`idx`, `dout_last`=(`idx`==15).
    - On a handshake with `idx`<15: `idx`++.
    - On a handshake with `idx`=15: `idx`←0, `rp` toggles, and the frame is released.
    - After the release, stay in SEND if `occ_next`>0, with no bubble between frames; else go to IDLE.
  - No handshake: `dout_data`, `dout_ch` and `dout_last` hold stable. `dout_valid` never drops once asserted until the handshake.
- **Slot protection.** A capture never writes the slot currently being read. This holds structurally, because capture requires a free slot or the same-cycle release of that slot; the write then targets slot `wp`, which equals `rp` only when the slot is being freed that cycle. The read output is taken before the write (registered slot storage).
- **Clear vs drop.** `clr_ovf` clears `overflow` and `drop_cnt` to 0. If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_cnt`=1.
- **Output values.** All outputs come from registers or from the registered buffer indexed by registered `rp`/`idx`. There are no combinational paths from `srdyo` or `dout_ready` to outputs.

## Timing
- **Reset values.** `dout_valid`=0, `dout_data`=0, `dout_ch`=0, `dout_last`=0, `overflow`=0, `drop_cnt`=0. Internally `occ`=0, `wp`=`rp`=0, `idx`=0, FSM=IDLE.
- **Reset mid-frame.** The partially sent frame and any buffered frame are discarded.
- **Latency.** With the buffer empty, `srdyo` at cycle t gives `dout_valid`=1 with ch 0 at t+1.
- **Throughput.** With `dout_ready` held at 1, a frame drains in 16 cycles, ch 15 at t+16. The next buffered frame's ch 0 appears at t+17.
- **Sustained rate.** Sustained capture needs `srdyo` spacing ≥16 cycles with `dout_ready`=1. Back-to-back `srdyo` strobes fill both slots and the third is dropped unless a release coincides.
- **Simultaneous events.** `srdyo` in the same cycle as a ch-15 release with `occ`=2 is accepted, and `occ` stays 2.

## Test plan
- **Basic capture and drain.** After reset, pulse `srdyo` with `chN_x_lin`=N·0x1000+N and hold `dout_ready`=1. Expect ch 0..15 with matching values on cycles t+1..t+16, `dout_last` only on ch 15, then `dout_valid`=0.
- **Backpressure.** Drive `dout_ready` with a 1-0-1-1-0 pattern. Each sample appears exactly once, in order, and is held stable while `dout_ready`=0.
- **Overflow.** Hold `dout_ready`=0 and pulse `srdyo` three times. Expect `overflow`=1 and `drop_cnt`=1; frames 1 and 2 then drain intact, and frame 3's data never appears.
- **Coincident release.** With `occ`=2, assert `srdyo` on the ch-15 handshake cycle. Expect no drop, `occ` stays 2, and three frames in total output in order.
- **Clear vs drop.** Assert `clr_ovf` and a dropped `srdyo` in the same cycle with `drop_cnt`=5. Expect `drop_cnt`=1 and `overflow`=1. A lone `clr_ovf` then gives 0/0.
- **Async reset mid-stream.** Assert `reset` at ch 7 between edges. Outputs go to 0 immediately. After release, a new `srdyo` streams from ch 0 with the new data only.
